// File: rtl/cp0_regfile_pkg.sv
// CP0 shared definitions: register numbers, pipeline exception codes, ExcCode values,
// Status/Cause bit positions and writable masks, plus the exception-code decoder.
package cp0_regfile_pkg;

  // CP0 register numbers (mtc0/mfc0 rd field)
  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;
  localparam logic [4:0] RegPrid     = 5'd15;
  localparam logic [4:0] RegConfig   = 5'd16;

  // Exception words emitted by the pipeline's exception decoder
  localparam logic [31:0] ExcInterrupt = 32'h0000_0001;
  localparam logic [31:0] ExcAdel      = 32'h0000_0004;
  localparam logic [31:0] ExcAdes      = 32'h0000_0005;
  localparam logic [31:0] ExcSyscall   = 32'h0000_0008;
  localparam logic [31:0] ExcBreak     = 32'h0000_0009;
  localparam logic [31:0] ExcRi        = 32'h0000_000a;
  localparam logic [31:0] ExcOverflow  = 32'h0000_000c;
  localparam logic [31:0] ExcEret      = 32'h0000_000e;

  // Cause.ExcCode field values
  localparam logic [4:0] CodeInt  = 5'd0;
  localparam logic [4:0] CodeAdel = 5'd4;
  localparam logic [4:0] CodeAdes = 5'd5;
  localparam logic [4:0] CodeSys  = 5'd8;
  localparam logic [4:0] CodeBp   = 5'd9;
  localparam logic [4:0] CodeRi   = 5'd10;
  localparam logic [4:0] CodeOv   = 5'd12;

  // Status / Cause layout
  localparam int unsigned StatusExl = 1;
  localparam logic [31:0] StatusReset  = 32'h0040_0000;
  localparam logic [31:0] StatusWrMask = 32'h0040_FF03;  // BEV, IM[7:0], EXL, IE

  typedef struct packed {
    logic       take;     // real exception: record it
    logic       eret;     // return from exception
    logic       badaddr;  // address error: capture BadVAddr
    logic [4:0] code;     // ExcCode to record
  } exc_dec_t;

  function automatic exc_dec_t decode_exc(input logic [31:0] etype);
    exc_dec_t d;
    d      = '0;
    d.take = 1'b1;
    case (etype)
      ExcInterrupt: d.code = CodeInt;
      ExcAdel:      begin d.code = CodeAdel; d.badaddr = 1'b1; end
      ExcAdes:      begin d.code = CodeAdes; d.badaddr = 1'b1; end
      ExcSyscall:   d.code = CodeSys;
      ExcBreak:     d.code = CodeBp;
      ExcRi:        d.code = CodeRi;
      ExcOverflow:  d.code = CodeOv;
      ExcEret:      begin d.take = 1'b0; d.eret = 1'b1; end
      default:      d.take = 1'b0;  // zero or unrecognised: no effect
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cp0_count_timer.sv
// CP0 Count/Compare timer.
//   clk, rst       : clock, synchronous active-high reset
//   count_we_i     : mtc0 to Count this cycle
//   compare_we_i   : mtc0 to Compare this cycle
//   wdata_i        : mtc0 data
//   count_o        : Count
//   compare_o      : Compare
//   timer_int_o    : timer interrupt pending (sticky until next Compare write)
module cp0_count_timer #(
  parameter bit COUNT_DIV2 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        toggle_q, toggle_d;
  logic        timer_q, timer_d;

  always_comb begin
    count_d   = count_q;
    toggle_d  = toggle_q;
    compare_d = compare_q;
    timer_d   = timer_q;

    if (count_we_i) begin
      count_d  = wdata_i;
      toggle_d = 1'b0;
    end else if (COUNT_DIV2) begin
      toggle_d = ~toggle_q;
      if (toggle_q) count_d = count_q + 32'd1;
    end else begin
      count_d = count_q + 32'd1;
    end

    if (compare_we_i) compare_d = wdata_i;

    // A match sets the flag even if Compare is being rewritten this cycle
    if ((compare_q != 32'd0) && (count_q == compare_q)) begin
      timer_d = 1'b1;
    end else if (compare_we_i) begin
      timer_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      toggle_q  <= 1'b0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      toggle_q  <= toggle_d;
      timer_q   <= timer_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_q;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register block: records exceptions, tracks interrupts, serves mfc0.
//   clk, rst            : clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i: mtc0 write port
//   raddr_i/rdata_o     : mfc0 read port (combinational, no write bypass)
//   int_i               : hardware interrupt lines
//   excepttype_i, pc_i, is_delayslot_i, badaddr_i : exception report from execute
//   count_o .. badvaddr_o, timer_int_o            : register state to the pipeline
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
  parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000,
  parameter bit          COUNT_DIV2   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] wdata_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] pc_i,
  input  logic        is_delayslot_i,
  input  logic [31:0] badaddr_i,
  output logic [31:0] rdata_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;        // Cause.IP[7:2]
  logic [1:0]  sw_q, sw_d;        // Cause.IP[1:0], software interrupts
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        timer_int;
  exc_dec_t    exc;

  cp0_count_timer #(
    .COUNT_DIV2(COUNT_DIV2)
  ) u_count_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (we_i && (waddr_i == RegCount)),
    .compare_we_i (we_i && (waddr_i == RegCompare)),
    .wdata_i      (wdata_i),
    .count_o      (count_o),
    .compare_o    (compare_o),
    .timer_int_o  (timer_int)
  );

  assign exc = decode_exc(excepttype_i);

  always_comb begin
    status_d   = status_q;
    bd_d       = bd_q;
    sw_d       = sw_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    ip_d       = {int_i[5] | timer_int, int_i[4:0]};

    // mtc0 first; exception/eret below overrides only the fields it owns
    if (we_i) begin
      case (waddr_i)
        RegStatus: status_d = (status_q & ~StatusWrMask) | (wdata_i & StatusWrMask);
        RegCause:  sw_d     = wdata_i[9:8];
        RegEpc:    epc_d    = wdata_i;
        default:   ;
      endcase
    end

    if (exc.eret) begin
      status_d[StatusExl] = 1'b0;
    end else if (exc.take) begin
      // A nested exception keeps the original return point
      if (!status_q[StatusExl]) begin
        epc_d = is_delayslot_i ? (pc_i - 32'd4) : pc_i;
        bd_d  = is_delayslot_i;
      end
      status_d[StatusExl] = 1'b1;
      exccode_d           = exc.code;
      if (exc.badaddr) badvaddr_d = badaddr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q   <= StatusReset;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      sw_q       <= 2'd0;
      exccode_q  <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      status_q   <= status_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      sw_q       <= sw_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // Cause.TI is the timer flag itself, so both clear together on a Compare write
  assign cause_o     = {bd_q, timer_int, 14'd0, ip_q, sw_q, 1'b0, exccode_q, 2'b00};
  assign status_o    = status_q;
  assign epc_o       = epc_q;
  assign badvaddr_o  = badvaddr_q;
  assign timer_int_o = timer_int;

  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      RegBadVAddr: rdata_o = badvaddr_q;
      RegCount:    rdata_o = count_o;
      RegCompare:  rdata_o = compare_o;
      RegStatus:   rdata_o = status_q;
      RegCause:    rdata_o = cause_o;
      RegEpc:      rdata_o = epc_q;
      RegPrid:     rdata_o = PRID_VALUE;
      RegConfig:   rdata_o = CONFIG_VALUE;
      default:     rdata_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_regfile.sv
module tb_cp0_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] wdata_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i, pc_i, badaddr_i;
  logic        is_delayslot_i;
  logic [31:0] rdata_o, count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o;
  logic        timer_int_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cp0_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .we_i           (we_i),
    .waddr_i        (waddr_i),
    .raddr_i        (raddr_i),
    .wdata_i        (wdata_i),
    .int_i          (int_i),
    .excepttype_i   (excepttype_i),
    .pc_i           (pc_i),
    .is_delayslot_i (is_delayslot_i),
    .badaddr_i      (badaddr_i),
    .rdata_o        (rdata_o),
    .count_o        (count_o),
    .compare_o      (compare_o),
    .status_o       (status_o),
    .cause_o        (cause_o),
    .epc_o          (epc_o),
    .badvaddr_o     (badvaddr_o),
    .timer_int_o    (timer_int_o)
  );

  // ---------------- reference model (COUNT_DIV2 = 1) ----------------
  // Count = value last loaded + half the clocks seen since the load.
  logic [31:0] m_base;
  int unsigned m_ticks;
  logic [31:0] m_compare, m_status, m_epc, m_badv;
  logic        m_ti, m_bd;
  logic [5:0]  m_ip;
  logic [1:0]  m_sw;
  logic [4:0]  m_exc;

  function automatic logic [31:0] m_count();
    return m_base + 32'(m_ticks >> 1);
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip, m_sw, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count();
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4220;
      5'd16:   return 32'h0000_8000;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: predict next state from current inputs, clock, then commit.
  task automatic step();
    logic [31:0] cnt, n_base, n_compare, n_status, n_epc, n_badv;
    int unsigned n_ticks;
    logic        n_ti, n_bd, is_exc, is_eret, is_bad;
    logic [5:0]  n_ip;
    logic [1:0]  n_sw;
    logic [4:0]  n_exc, code;
    cnt = m_count();
    n_base = m_base; n_ticks = m_ticks + 1; n_compare = m_compare; n_ti = m_ti;
    n_status = m_status; n_epc = m_epc; n_badv = m_badv; n_bd = m_bd;
    n_ip = {int_i[5] | m_ti, int_i[4:0]}; n_sw = m_sw; n_exc = m_exc;
    if (rst) begin
      n_base = 0; n_ticks = 0; n_compare = 0; n_ti = 0; n_status = 32'h0040_0000;
      n_epc = 0; n_badv = 0; n_bd = 0; n_ip = 0; n_sw = 0; n_exc = 0;
    end else begin
      if (we_i && waddr_i == 5'd9)  begin n_base = wdata_i; n_ticks = 0; end
      if (we_i && waddr_i == 5'd11) n_compare = wdata_i;
      if (m_compare != 0 && cnt == m_compare) n_ti = 1'b1;
      else if (we_i && waddr_i == 5'd11) n_ti = 1'b0;
      if (we_i && waddr_i == 5'd12)
        n_status = (m_status & ~32'h0040_FF03) | (wdata_i & 32'h0040_FF03);
      if (we_i && waddr_i == 5'd13) n_sw = wdata_i[9:8];
      if (we_i && waddr_i == 5'd14) n_epc = wdata_i;
      is_exc = 1'b1; is_eret = 1'b0; is_bad = 1'b0; code = 5'd0;
      case (excepttype_i)
        32'h1:   code = 5'd0;
        32'h4:   begin code = 5'd4; is_bad = 1'b1; end
        32'h5:   begin code = 5'd5; is_bad = 1'b1; end
        32'h8:   code = 5'd8;
        32'h9:   code = 5'd9;
        32'ha:   code = 5'd10;
        32'hc:   code = 5'd12;
        32'he:   begin is_exc = 1'b0; is_eret = 1'b1; end
        default: is_exc = 1'b0;
      endcase
      if (is_eret) n_status[1] = 1'b0;
      if (is_exc) begin
        if (!m_status[1]) begin
          n_epc = is_delayslot_i ? pc_i - 32'd4 : pc_i;
          n_bd  = is_delayslot_i;
        end
        n_status[1] = 1'b1;
        n_exc = code;
        if (is_bad) n_badv = badaddr_i;
      end
    end
    @(posedge clk);
    #1;
    m_base = n_base; m_ticks = n_ticks; m_compare = n_compare; m_ti = n_ti;
    m_status = n_status; m_epc = n_epc; m_badv = n_badv; m_bd = n_bd;
    m_ip = n_ip; m_sw = n_sw; m_exc = n_exc;
  endtask

  task automatic idle();
    rst = 1'b0; we_i = 1'b0; waddr_i = 5'd0; raddr_i = 5'd0; wdata_i = 32'd0;
    int_i = 6'd0; excepttype_i = 32'd0; pc_i = 32'd0; is_delayslot_i = 1'b0;
    badaddr_i = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] exp_r [4];
    logic [4:0]  addr_r [4];
    do_reset();
    addr_r = '{5'd12, 5'd15, 5'd9, 5'd16};
    exp_r  = '{32'h0040_0000, 32'h0000_4220, 32'd0, 32'h0000_8000};
    for (int i = 0; i < 4; i++) begin
      raddr_i = addr_r[i];
      #1;
      n_cmp++;
      if (rdata_o !== exp_r[i]) begin
        n_fail++;
        $display("FAIL reset_read r%0d got=%h exp=%h", addr_r[i], rdata_o, exp_r[i]);
      end
    end
    n_cmp++;
    if (timer_int_o !== 1'b0 || cause_o !== 32'd0 || epc_o !== 32'd0 || badvaddr_o !== 32'd0
        || compare_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_regs got ti=%b cause=%h epc=%h bv=%h cmp=%h exp all 0",
               timer_int_o, cause_o, epc_o, badvaddr_o, compare_o);
    end
    repeat (10) step();
    n_cmp++;
    if (count_o !== 32'd5) begin
      n_fail++;
      $display("FAIL reset_count10 got=%0d exp=5", count_o);
    end
  endtask

  task automatic test_timer();
    bit found;
    do_reset();
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd8; step();
    waddr_i = 5'd9; wdata_i = 32'd0; step();
    we_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (count_o === 32'd8) found = 1'b1;
      else step();
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL timer_reach8 got count=%0d exp=8 within 40 clocks", count_o);
    end
    step();
    n_cmp++;
    if (timer_int_o !== 1'b1 || cause_o[30] !== 1'b1) begin
      n_fail++;
      $display("FAIL timer_set got ti=%b TI=%b exp 1/1", timer_int_o, cause_o[30]);
    end
    step();
    n_cmp++;
    if (cause_o[15] !== 1'b1 || timer_int_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timer_ip7 got ip7=%b ti=%b exp 1/1", cause_o[15], timer_int_o);
    end
    we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'd100; step();
    we_i = 1'b0;
    n_cmp++;
    if (timer_int_o !== 1'b0 || cause_o[30] !== 1'b0 || compare_o !== 32'd100) begin
      n_fail++;
      $display("FAIL timer_clear got ti=%b TI=%b cmp=%0d exp 0/0/100",
               timer_int_o, cause_o[30], compare_o);
    end
    step();
    n_cmp++;
    if (cause_o[15] !== 1'b0) begin
      n_fail++;
      $display("FAIL timer_ip7_clear got=%b exp=0", cause_o[15]);
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'hFFFF_FFFF; step();
    we_i = 1'b0;
    step();
    step();
    n_cmp++;
    if (count_o !== 32'd0) begin
      n_fail++;
      $display("FAIL count_wrap got=%h exp=00000000", count_o);
    end
  endtask

  task automatic test_adel();
    do_reset();
    excepttype_i = 32'h4; pc_i = 32'hBFC0_0100; badaddr_i = 32'h3; is_delayslot_i = 1'b0;
    step();
    idle();
    n_cmp++;
    if (epc_o !== 32'hBFC0_0100 || badvaddr_o !== 32'h3 || status_o !== 32'h0040_0002
        || cause_o[6:2] !== 5'd4 || cause_o[31] !== 1'b0) begin
      n_fail++;
      $display("FAIL adel got epc=%h bv=%h st=%h cause=%h exp BFC00100/3/00400002/code4",
               epc_o, badvaddr_o, status_o, cause_o);
    end
  endtask

  task automatic test_nested_delayslot();
    do_reset();
    excepttype_i = 32'hc; pc_i = 32'h8000_0010; is_delayslot_i = 1'b1; badaddr_i = 32'h55;
    step();
    n_cmp++;
    if (epc_o !== 32'h8000_000C || cause_o[31] !== 1'b1 || cause_o[6:2] !== 5'd12
        || badvaddr_o !== 32'd0) begin
      n_fail++;
      $display("FAIL ov_delayslot got epc=%h cause=%h bv=%h exp 8000000C/BD=1,code12/0",
               epc_o, cause_o, badvaddr_o);
    end
    excepttype_i = 32'h8; pc_i = 32'h8000_0100; is_delayslot_i = 1'b0;
    step();
    idle();
    n_cmp++;
    if (epc_o !== 32'h8000_000C || cause_o[6:2] !== 5'd8 || cause_o[31] !== 1'b1
        || status_o[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL nested_sys got epc=%h cause=%h st=%h exp 8000000C/BD=1,code8/EXL=1",
               epc_o, cause_o, status_o);
    end
  endtask

  task automatic test_mtc0_with_eret();
    do_reset();
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hFFFF_FFFF; excepttype_i = 32'he;
    step();
    idle();
    n_cmp++;
    if (status_o !== 32'h0040_FF01) begin
      n_fail++;
      $display("FAIL mtc0_eret got=%h exp=0040FF01", status_o);
    end
  endtask

  task automatic test_cause_write();
    do_reset();
    int_i = 6'b000001; we_i = 1'b1; waddr_i = 5'd13; wdata_i = 32'hFFFF_FFFF;
    step();
    we_i = 1'b0;
    n_cmp++;
    if (cause_o !== 32'h0000_0700) begin
      n_fail++;
      $display("FAIL cause_write got=%h exp=00000700", cause_o);
    end
    raddr_i = 5'd7;
    #1;
    n_cmp++;
    if (rdata_o !== 32'd0) begin
      n_fail++;
      $display("FAIL read_unimpl got=%h exp=0", rdata_o);
    end
    idle();
  endtask

  task automatic test_random();
    logic [4:0]  waddrs [9];
    logic [31:0] excs [10];
    waddrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    excs   = '{32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he, 32'h3, 32'h7};
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      we_i = ($urandom_range(0, 2) == 0);
      waddr_i = waddrs[$urandom_range(0, 8)];
      wdata_i = $urandom();
      if (waddr_i == 5'd11 && $urandom_range(0, 1) == 1)
        wdata_i = m_count() + 32'($urandom_range(0, 6));
      if (waddr_i == 5'd9 && $urandom_range(0, 3) == 0) wdata_i = 32'hFFFF_FFFD;
      int_i = 6'($urandom());
      excepttype_i = ($urandom_range(0, 2) == 0) ? excs[$urandom_range(0, 9)] : 32'd0;
      pc_i = $urandom();
      badaddr_i = $urandom();
      is_delayslot_i = 1'($urandom());
      raddr_i = 5'($urandom_range(0, 20));
      step();
      n_cmp++;
      if (count_o !== m_count() || compare_o !== m_compare || timer_int_o !== m_ti) begin
        n_fail++;
        $display("FAIL rand_timer cyc=%0d got cnt=%h cmp=%h ti=%b exp cnt=%h cmp=%h ti=%b",
                 c, count_o, compare_o, timer_int_o, m_count(), m_compare, m_ti);
      end
      n_cmp++;
      if (status_o !== m_status || cause_o !== m_cause()) begin
        n_fail++;
        $display("FAIL rand_status_cause cyc=%0d got st=%h ca=%h exp st=%h ca=%h",
                 c, status_o, cause_o, m_status, m_cause());
      end
      n_cmp++;
      if (epc_o !== m_epc || badvaddr_o !== m_badv) begin
        n_fail++;
        $display("FAIL rand_epc_bv cyc=%0d got epc=%h bv=%h exp epc=%h bv=%h",
                 c, epc_o, badvaddr_o, m_epc, m_badv);
      end
      n_cmp++;
      if (rdata_o !== m_read(raddr_i)) begin
        n_fail++;
        $display("FAIL rand_read cyc=%0d r%0d got=%h exp=%h",
                 c, raddr_i, rdata_o, m_read(raddr_i));
      end
    end
    idle();
  endtask

  initial begin
    idle();
    m_base = 0; m_ticks = 0; m_compare = 0; m_ti = 0; m_status = 0; m_epc = 0;
    m_badv = 0; m_bd = 0; m_ip = 0; m_sw = 0; m_exc = 0;
    test_reset();
    test_timer();
    test_count_wrap();
    test_adel();
    test_nested_delayslot();
    test_mtc0_with_eret();
    test_cause_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
